// File: rtl/qft_stream_core.sv
// qft_stream_core: frame-based N-qubit QFT engine.
// Loads a 2^N amplitude frame, runs an in-place radix-2 DIF transform
// (one butterfly per cycle), then streams the result in natural order
// by reading the storage in bit-reversed index order.
module qft_stream_core #(
    parameter int N_QUBITS    = 3,
    parameter int TOTAL_WIDTH = 8,
    parameter int FRAC_WIDTH  = 4,
    parameter int COEF_FRAC   = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [TOTAL_WIDTH-1:0] in_re,
    input  logic signed [TOTAL_WIDTH-1:0] in_im,
    input  logic                          in_last,
    input  logic                          inverse,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [TOTAL_WIDTH-1:0] out_re,
    output logic signed [TOTAL_WIDTH-1:0] out_im,
    output logic [N_QUBITS-1:0]           out_idx,
    output logic                          out_last,
    output logic                          busy,
    output logic                          frame_err
);
    localparam int L    = 1 << N_QUBITS;
    localparam int HALF = L / 2;
    localparam int NBF  = N_QUBITS * HALF;
    localparam int BW   = $clog2(NBF);
    localparam int CW   = COEF_FRAC + 2;
    localparam int AW   = 2 * TOTAL_WIDTH + 2 * CW + 4;

    localparam logic [N_QUBITS-1:0] LAST     = '1;
    localparam logic signed [AW-1:0] HALF_LSB = AW'(1) << (COEF_FRAC - 1);
    localparam logic signed [AW-1:0] MAXV     = AW'((1 << (TOTAL_WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] MINV     = AW'(-(1 << (TOTAL_WIDTH - 1)));

    // The twiddle table is built for up to 32 points and amplitudes must keep an integer part.
    if (N_QUBITS < 2 || N_QUBITS > 5 || FRAC_WIDTH >= TOTAL_WIDTH ||
        COEF_FRAC < 1 || COEF_FRAC > 29) begin : g_cfg_check
        $error("qft_stream_core: unsupported parameter set");
    end

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

    // sin(n*pi/16), n = 0..8, rounded to COEF_FRAC fraction bits (from a Q30 table).
    function automatic logic signed [CW-1:0] qsin(input int n);
        logic [31:0] v;
        logic [31:0] r;
        case (n)
            0:       v = 32'd0;
            1:       v = 32'd209476638;
            2:       v = 32'd410903207;
            3:       v = 32'd596538995;
            4:       v = 32'd759250125;
            5:       v = 32'd892783698;
            6:       v = 32'd992008094;
            7:       v = 32'd1053110176;
            8:       v = 32'd1073741824;
            default: v = 32'd0;
        endcase
        r = (v + (32'd1 << (29 - COEF_FRAC))) >> (30 - COEF_FRAC);
        return signed'(CW'(r));
    endfunction

    // Round half up and drop the coefficient fraction bits.
    function automatic logic signed [AW-1:0] rnd(input logic signed [AW-1:0] x);
        return (x + HALF_LSB) >>> COEF_FRAC;
    endfunction

    // Clamp a wide result into the amplitude range.
    function automatic logic signed [TOTAL_WIDTH-1:0] sat(input logic signed [AW-1:0] x);
        if (x > MAXV) return MAXV[TOTAL_WIDTH-1:0];
        if (x < MINV) return MINV[TOTAL_WIDTH-1:0];
        return x[TOTAL_WIDTH-1:0];
    endfunction

    function automatic logic [N_QUBITS-1:0] bitrev(input logic [N_QUBITS-1:0] k);
        for (int b = 0; b < N_QUBITS; b++) bitrev[b] = k[N_QUBITS-1-b];
    endfunction

    state_t                        state;
    logic signed [TOTAL_WIDTH-1:0] slot_re [L];
    logic signed [TOTAL_WIDTH-1:0] slot_im [L];
    logic [N_QUBITS-1:0]           ld_cnt;
    logic [BW-1:0]                 bf_cnt;
    logic                          inv_q;

    logic [N_QUBITS-1:0]           idx_a, idx_b, nxt_idx;
    logic signed [CW-1:0]          w_re, w_im, c_rt2;
    logic signed [AW-1:0]          a_re, a_im, b_re, b_im, d_re, d_im, t_re, t_im;
    logic signed [TOTAL_WIDTH-1:0] na_re, na_im, nb_re, nb_im;

    assign nxt_idx = out_idx + N_QUBITS'(1);

    // Current butterfly: pair addressing, twiddle lookup and the a'/b' arithmetic.
    always_comb begin
        int stage, j, lg, lo, m, n32;
        stage = int'(bf_cnt) / HALF;
        j     = int'(bf_cnt) % HALF;
        lg    = N_QUBITS - 1 - stage;
        lo    = j % (1 << lg);
        m     = lo << stage;
        idx_a = N_QUBITS'(((j >> lg) << (lg + 1)) | lo);
        idx_b = N_QUBITS'(int'(idx_a) + (1 << lg));
        n32   = m << (5 - N_QUBITS);
        if (n32 <= 8) begin
            w_re = qsin(8 - n32);
            w_im = qsin(n32);
        end else begin
            w_re = -qsin(n32 - 8);
            w_im = qsin(16 - n32);
        end
        if (inv_q) w_im = -w_im;
        c_rt2 = qsin(4);
        a_re  = AW'(slot_re[idx_a]);
        a_im  = AW'(slot_im[idx_a]);
        b_re  = AW'(slot_re[idx_b]);
        b_im  = AW'(slot_im[idx_b]);
        d_re  = a_re - b_re;
        d_im  = a_im - b_im;
        t_re  = rnd(d_re * AW'(w_re) - d_im * AW'(w_im));
        t_im  = rnd(d_re * AW'(w_im) + d_im * AW'(w_re));
        na_re = sat(rnd((a_re + b_re) * AW'(c_rt2)));
        na_im = sat(rnd((a_im + b_im) * AW'(c_rt2)));
        nb_re = sat(rnd(t_re * AW'(c_rt2)));
        nb_im = sat(rnd(t_im * AW'(c_rt2)));
    end

    // Frame sequencer: load, in-place compute, bit-reversed drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            ld_cnt    <= '0;
            bf_cnt    <= '0;
            inv_q     <= 1'b0;
            for (int k = 0; k < L; k++) begin
                slot_re[k] <= '0;
                slot_im[k] <= '0;
            end
        end else begin
            case (state)
                S_LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        slot_re[ld_cnt] <= in_re;
                        slot_im[ld_cnt] <= in_im;
                        ld_cnt          <= ld_cnt + N_QUBITS'(1);
                        if (ld_cnt == '0) inv_q <= inverse;
                        // Beat 0 starts a fresh error window; a misplaced in_last sets it.
                        frame_err <= ((ld_cnt != '0) && frame_err) || (in_last != (ld_cnt == LAST));
                        if (ld_cnt == LAST) begin
                            state    <= S_COMPUTE;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            bf_cnt   <= '0;
                        end
                    end
                end
                S_COMPUTE: begin
                    slot_re[idx_a] <= na_re;
                    slot_im[idx_a] <= na_im;
                    slot_re[idx_b] <= nb_re;
                    slot_im[idx_b] <= nb_im;
                    if (bf_cnt == BW'(NBF - 1)) begin
                        state  <= S_DRAIN;
                        bf_cnt <= '0;
                    end else begin
                        bf_cnt <= bf_cnt + BW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                        out_re    <= slot_re[0];
                        out_im    <= slot_im[0];
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= S_LOAD;
                        end else begin
                            out_idx  <= nxt_idx;
                            out_last <= (nxt_idx == LAST);
                            out_re   <= slot_re[bitrev(nxt_idx)];
                            out_im   <= slot_im[bitrev(nxt_idx)];
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_qft_stream_core.sv
// Testbench for qft_stream_core at N_QUBITS=3: directed and random frames
// compared against an ideal unitary DFT computed with real arithmetic.
`timescale 1ns/1ps
module tb_qft_stream_core;
    localparam int    NQ = 3;
    localparam int    TW = 8;
    localparam int    L  = 1 << NQ;
    localparam real   PI = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [TW-1:0] in_re = '0;
    logic signed [TW-1:0] in_im = '0;
    logic                 in_last = 1'b0;
    logic                 inverse = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [TW-1:0] out_re;
    logic signed [TW-1:0] out_im;
    logic [NQ-1:0]        out_idx;
    logic                 out_last;
    logic                 busy;
    logic                 frame_err;

    qft_stream_core #(.N_QUBITS(NQ), .TOTAL_WIDTH(TW), .FRAC_WIDTH(4), .COEF_FRAC(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last), .inverse(inverse),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int  tests = 0;
    int  fails = 0;
    int  fr_re [L];
    int  fr_im [L];
    int  got_re [L];
    int  got_im [L];
    real ex_re [L];
    real ex_im [L];
    time t_in, t_v;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input real exp, input real tol);
        real d;
        d = real'(obs) - exp;
        tests++;
        assert (d <= tol && d >= -tol) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0.2f within %0.1f", tag, obs, exp, tol);
        end
    endtask

    // Ideal unitary QFT of fr_*: X[k] = 1/sqrt(L) * sum x[n] exp(+/- 2*pi*j*n*k/L).
    task automatic model(input bit inv);
        for (int k = 0; k < L; k++) begin
            real sr, si, ang;
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < L; n++) begin
                ang = (inv ? -1.0 : 1.0) * 2.0 * PI * real'(n * k) / real'(L);
                sr += real'(fr_re[n]) * $cos(ang) - real'(fr_im[n]) * $sin(ang);
                si += real'(fr_re[n]) * $sin(ang) + real'(fr_im[n]) * $cos(ang);
            end
            ex_re[k] = sr / $sqrt(real'(L));
            ex_im[k] = si / $sqrt(real'(L));
        end
    endtask

    task automatic clear_frame();
        for (int n = 0; n < L; n++) begin
            fr_re[n] = 0;
            fr_im[n] = 0;
        end
    endtask

    task automatic random_frame();
        for (int n = 0; n < L; n++) begin
            fr_re[n] = int'($urandom_range(24)) - 12;
            fr_im[n] = int'($urandom_range(24)) - 12;
        end
    endtask

    task automatic push_frame(input bit inv, input int last_pos);
        for (int b = 0; b < L; b++) begin
            int guard;
            @(negedge clk);
            in_valid = 1'b1;
            in_re    = TW'(fr_re[b]);
            in_im    = TW'(fr_im[b]);
            in_last  = (b == last_pos);
            inverse  = inv;
            guard    = 0;
            while (in_ready !== 1'b1 && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 40) begin
                check("in_ready_wait", int'(in_ready), 1);
                break;
            end
            @(posedge clk);
            t_in = $time;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_ready_after_load", int'(in_ready), 0);
        check("busy_after_load", int'(busy), 1);
    endtask

    task automatic collect(input int mode, input int stall_beat, input int stall_len, input real tol);
        int k, cyc, stalled;
        bit seen;
        k = 0;
        cyc = 0;
        stalled = 0;
        seen = 1'b0;
        while (k < L && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                t_v  = $time;
            end
            if (out_valid === 1'b1 && k == stall_beat && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
                check("hold_idx", int'(out_idx), k);
                check_near("hold_re", int'(out_re), ex_re[k], tol);
                check_near("hold_im", int'(out_im), ex_im[k], tol);
                check("hold_in_ready", int'(in_ready), 0);
            end else begin
                out_ready = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
                if (out_valid === 1'b1 && out_ready) begin
                    got_re[k] = int'(out_re);
                    got_im[k] = int'(out_im);
                    check($sformatf("out_idx[%0d]", k), int'(out_idx), k);
                    check($sformatf("out_last[%0d]", k), int'(out_last), int'(k == L - 1));
                    check($sformatf("busy[%0d]", k), int'(busy), 1);
                    if (k < L - 1) check("in_ready_drain", int'(in_ready), 0);
                    k++;
                end
            end
        end
        if (k < L) check("drain_beats", k, L);
        if (seen) check("first_valid_latency", int'((t_v - t_in) / 10), 13);
        @(negedge clk);
        out_ready = 1'b1;
        check("out_valid_after_drain", int'(out_valid), 0);
        check("in_ready_after_drain", int'(in_ready), 1);
        check("busy_after_drain", int'(busy), 0);
    endtask

    task automatic compare_model(input string tag, input real tol);
        for (int k = 0; k < L; k++) begin
            check_near($sformatf("%s re[%0d]", tag, k), got_re[k], ex_re[k], tol);
            check_near($sformatf("%s im[%0d]", tag, k), got_im[k], ex_im[k], tol);
        end
    endtask

    initial begin
        int vcount;
        bit inv;

        // Reset held: all outputs low / zero.
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst in_ready", int'(in_ready), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_re", int'(out_re), 0);
        check("rst out_im", int'(out_im), 0);
        check("rst out_idx", int'(out_idx), 0);
        check("rst out_last", int'(out_last), 0);
        check("rst busy", int'(busy), 0);
        check("rst frame_err", int'(frame_err), 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready after rst", int'(in_ready), 1);

        // |000> forward: every output exactly (6,0).
        clear_frame();
        fr_re[0] = 16;
        push_frame(1'b0, L - 1);
        collect(0, -1, 0, 0.0);
        for (int k = 0; k < L; k++) begin
            check($sformatf("basis0 re[%0d]", k), got_re[k], 6);
            check($sformatf("basis0 im[%0d]", k), got_im[k], 0);
        end
        check("frame_err clean", int'(frame_err), 0);

        // |110> forward with a 5-cycle stall on beat 3.
        clear_frame();
        fr_re[6] = 16;
        model(1'b0);
        push_frame(1'b0, L - 1);
        collect(0, 3, 5, 2.0);
        compare_model("fwd110", 2.0);

        // |110> inverse.
        model(1'b1);
        push_frame(1'b1, L - 1);
        collect(0, -1, 0, 2.0);
        compare_model("inv110", 2.0);

        // Round trip: inverse then forward on |011>.
        clear_frame();
        fr_re[3] = 16;
        model(1'b1);
        push_frame(1'b1, L - 1);
        collect(0, -1, 0, 3.0);
        compare_model("rt_inv", 3.0);
        for (int n = 0; n < L; n++) begin
            fr_re[n] = got_re[n];
            fr_im[n] = got_im[n];
        end
        model(1'b0);
        push_frame(1'b0, L - 1);
        collect(0, -1, 0, 4.0);
        check_near("rt peak re", got_re[3], 16.0, 3.0);
        check_near("rt peak im", got_im[3], 0.0, 3.0);
        compare_model("rt_fwd", 4.0);

        // All (127,0): DC term saturates, all others zero.
        for (int n = 0; n < L; n++) begin
            fr_re[n] = 127;
            fr_im[n] = 0;
        end
        push_frame(1'b0, L - 1);
        collect(0, -1, 0, 0.0);
        check("sat re[0]", got_re[0], 127);
        check("sat im[0]", got_im[0], 0);
        for (int k = 1; k < L; k++) begin
            check($sformatf("sat re[%0d]", k), got_re[k], 0);
            check($sformatf("sat im[%0d]", k), got_im[k], 0);
        end

        // Early in_last on beat 5: error flagged, frame still 8 beats.
        random_frame();
        model(1'b0);
        push_frame(1'b0, 5);
        check("frame_err early last", int'(frame_err), 1);
        collect(0, -1, 0, 6.0);
        compare_model("errframe", 6.0);
        check("frame_err sticky", int'(frame_err), 1);

        // Next well-formed frame clears the error; random backpressure.
        random_frame();
        inv = 1'($urandom_range(1));
        model(inv);
        push_frame(inv, L - 1);
        check("frame_err cleared", int'(frame_err), 0);
        collect(1, -1, 0, 6.0);
        compare_model("rand_a", 6.0);

        // Reset pulse during COMPUTE aborts the frame.
        random_frame();
        push_frame(1'b0, L - 1);
        repeat (3) @(negedge clk);
        check("busy in compute", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("abort out_valid", int'(out_valid), 0);
        check("abort busy", int'(busy), 0);
        check("abort in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid === 1'b1) vcount++;
        end
        check("no output after abort", vcount, 0);
        check("in_ready after abort", int'(in_ready), 1);
        clear_frame();
        fr_re[0] = 16;
        push_frame(1'b0, L - 1);
        collect(0, -1, 0, 0.0);
        for (int k = 0; k < L; k++) begin
            check($sformatf("post-abort re[%0d]", k), got_re[k], 6);
            check($sformatf("post-abort im[%0d]", k), got_im[k], 0);
        end

        // Random frames, random direction, random backpressure.
        for (int r = 0; r < 3; r++) begin
            random_frame();
            inv = 1'($urandom_range(1));
            model(inv);
            push_frame(inv, L - 1);
            collect(1, -1, 0, 6.0);
            compare_model($sformatf("rand%0d", r), 6.0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
